// File: rtl/credit_scheduler_if.sv
// ============================================================================
// Module   : credit_scheduler_if
// Brief    : Request/return/grant bundle between requesters and the credit
//            scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface credit_scheduler_if #(
    parameter int NREQ = 4,
    parameter int CW   = 4
);
    logic                reinit;
    logic [CW-1:0]       init_credits;
    logic [NREQ-1:0]     req;
    logic [2*NREQ-1:0]   req_cost;
    logic                ret_valid;
    logic [1:0]          ret_amt;
    logic                drain;
    logic [NREQ-1:0]     grant;
    logic [CW-1:0]       credits;
    logic [CW-1:0]       credits_next;
    logic                drained;
    logic                ovf_err;

    modport master (
        output reinit, init_credits, req, req_cost, ret_valid, ret_amt, drain,
        input  grant, credits, credits_next, drained, ovf_err
    );

    modport slave (
        input  reinit, init_credits, req, req_cost, ret_valid, ret_amt, drain,
        output grant, credits, credits_next, drained, ovf_err
    );
endinterface

`default_nettype wire

// File: rtl/credit_scheduler.sv
// ============================================================================
// Module   : credit_scheduler
// Brief    : Round-robin arbiter that grants requesters against a shared,
//            saturating credit pool, with drain-to-full support.
// Revision : 1.0
// ============================================================================
`default_nettype none

module credit_scheduler #(
    parameter int NREQ        = 4,
    parameter int CW          = 4,
    parameter int MAX_CREDIT  = 15,
    parameter int INIT_CREDIT = 8
) (
    input  wire                 clk,
    input  wire                 rst,
    credit_scheduler_if.slave   bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_DRAINED = 2'd2;

    localparam logic [CW:0]   c_max      = (CW+1)'(MAX_CREDIT);
    localparam logic [CW-1:0] c_max_cw   = CW'(MAX_CREDIT);
    localparam logic [CW-1:0] c_init_cw  = CW'(INIT_CREDIT);
    localparam logic [PW-1:0] c_last     = PW'(NREQ - 1);
    localparam logic [NREQ-1:0] c_one    = NREQ'(1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [CW-1:0]   r_credits;
    logic [PW-1:0]   r_ptr;
    logic            r_ovf;

    logic            w_found;
    logic [PW-1:0]   w_cand;
    logic [1:0]      w_cost;
    logic [CW:0]     w_cost_ext;
    logic [CW:0]     w_ret_ext;
    logic [CW:0]     w_sum;
    logic            w_clip;
    logic            w_run;
    logic            w_drained;
    logic            w_grant_ok;
    logic [CW-1:0]   w_credits_next;
    logic [PW-1:0]   w_ptr_inc;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && bus.req[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_cand  = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_cost     = bus.req_cost[2*int'(w_cand) +: 2];
    assign w_cost_ext = {{(CW-1){1'b0}}, w_cost};
    assign w_ret_ext  = bus.ret_valid ? {{(CW-1){1'b0}}, bus.ret_amt} : '0;

    // Head-of-line only: an unaffordable candidate blocks everyone behind it.
    assign w_grant_ok = rst && !bus.reinit && w_run && w_found
                        && (w_cost_ext <= {1'b0, r_credits});

    // Grant cost never exceeds the pool, so the subtraction cannot wrap.
    assign w_sum  = {1'b0, r_credits} - (w_grant_ok ? w_cost_ext : '0) + w_ret_ext;
    assign w_clip = (w_sum > c_max);

    always_comb begin
        w_credits_next = w_clip ? c_max_cw : w_sum[CW-1:0];
        if (bus.reinit)
            w_credits_next = ({1'b0, bus.init_credits} > c_max) ? c_max_cw : bus.init_credits;
    end

    assign w_ptr_inc = (w_cand == c_last) ? '0 : w_cand + 1'b1;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:     if (bus.drain) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (!bus.drain)
                    w_state_nxt = S_RUN;
                else if (w_credits_next == c_max_cw)
                    w_state_nxt = S_DRAINED;
            end
            S_DRAINED: if (!bus.drain) w_state_nxt = S_RUN;
            default:   w_state_nxt = S_RUN;
        endcase
        if (bus.reinit)
            w_state_nxt = S_RUN;
    end

    // FSM: outputs
    always_comb begin
        w_run     = 1'b0;
        w_drained = 1'b0;
        case (r_state)
            S_RUN:     w_run     = 1'b1;
            S_DRAINED: w_drained = 1'b1;
            default: begin
                w_run     = 1'b0;
                w_drained = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_credits <= c_init_cw;
            r_ptr     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_credits <= w_credits_next;
            if (bus.reinit) begin
                r_ptr <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_grant_ok)
                    r_ptr <= w_ptr_inc;
                r_ovf <= r_ovf | (bus.ret_valid & w_clip);
            end
        end
    end

    assign bus.grant        = w_grant_ok ? (c_one << w_cand) : '0;
    assign bus.credits      = r_credits;
    assign bus.credits_next = w_credits_next;
    assign bus.drained      = w_drained;
    assign bus.ovf_err      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_credit_scheduler.sv
// ============================================================================
// Module   : tb_credit_scheduler
// Brief    : Directed vectors with a queued expectation per cycle, checked by
//            an independent negedge monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_credit_scheduler;
    logic clk;
    logic rst;

    credit_scheduler_if #(.NREQ(4), .CW(4)) bus ();

    credit_scheduler #(
        .NREQ(4), .CW(4), .MAX_CREDIT(15), .INIT_CREDIT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic [3:0] grant;
        logic [3:0] credits;
        logic [3:0] cnext;
        logic       drained;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.grant !== e.grant || bus.credits !== e.credits ||
                bus.credits_next !== e.cnext || bus.drained !== e.drained ||
                bus.ovf_err !== e.ovf) begin
                errors++;
                $display("FAIL %s: got grant=%b credits=%0d next=%0d drained=%b ovf=%b, want grant=%b credits=%0d next=%0d drained=%b ovf=%b",
                         e.name, bus.grant, bus.credits, bus.credits_next, bus.drained, bus.ovf_err,
                         e.grant, e.credits, e.cnext, e.drained, e.ovf);
            end
        end
    end

    task automatic cyc(input string nm, input logic r, input logic ri, input logic [3:0] ini,
                       input logic [3:0] rq, input logic [7:0] cst, input logic rv,
                       input logic [1:0] ra, input logic dr,
                       input logic [3:0] eg, input logic [3:0] ec, input logic [3:0] en,
                       input logic ed, input logic eo);
        exp_t x;
        @(posedge clk);
        #1;
        rst              = r;
        bus.reinit       = ri;
        bus.init_credits = ini;
        bus.req          = rq;
        bus.req_cost     = cst;
        bus.ret_valid    = rv;
        bus.ret_amt      = ra;
        bus.drain        = dr;
        x.name = nm; x.grant = eg; x.credits = ec; x.cnext = en; x.drained = ed; x.ovf = eo;
        q.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        bus.reinit = 1'b0; bus.init_credits = '0; bus.req = '0; bus.req_cost = '0;
        bus.ret_valid = 1'b0; bus.ret_amt = '0; bus.drain = 1'b0;
        repeat (2) @(posedge clk);

        //    name          rst ri ini  req    cost  rv ra dr  grant   cr  nxt dr ov
        cyc("rst_hold",      0, 0, 0, 4'hF, 8'h55, 0, 0, 0, 4'b0000,  8,  8, 0, 0);
        cyc("rot0",          1, 0, 0, 4'hF, 8'h55, 0, 0, 0, 4'b0001,  8,  7, 0, 0);
        cyc("rot1",          1, 0, 0, 4'hF, 8'h55, 0, 0, 0, 4'b0010,  7,  6, 0, 0);
        cyc("rot2",          1, 0, 0, 4'hF, 8'h55, 0, 0, 0, 4'b0100,  6,  5, 0, 0);
        cyc("rot3",          1, 0, 0, 4'hF, 8'h55, 0, 0, 0, 4'b1000,  5,  4, 0, 0);
        cyc("rot4",          1, 0, 0, 4'hF, 8'h55, 0, 0, 0, 4'b0001,  4,  3, 0, 0);
        cyc("rot_idle",      1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 4'b0000,  3,  3, 0, 0);

        cyc("hol_reinit",    1, 1, 2, 4'h0, 8'h00, 0, 0, 0, 4'b0000,  3,  2, 0, 0);
        cyc("hol_block",     1, 0, 0, 4'h3, 8'h07, 0, 0, 0, 4'b0000,  2,  2, 0, 0);
        cyc("hol_ret",       1, 0, 0, 4'h3, 8'h07, 1, 1, 0, 4'b0000,  2,  3, 0, 0);
        cyc("hol_grant",     1, 0, 0, 4'h3, 8'h07, 0, 0, 0, 4'b0001,  3,  0, 0, 0);
        cyc("hol_idle",      1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 4'b0000,  0,  0, 0, 0);

        cyc("ovf_reinit",    1, 1, 14, 4'h0, 8'h00, 0, 0, 0, 4'b0000, 0, 14, 0, 0);
        cyc("ovf_clip",      1, 0, 0, 4'h0, 8'h00, 1, 3, 0, 4'b0000, 14, 15, 0, 0);
        cyc("ovf_set",       1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 4'b0000, 15, 15, 0, 1);
        cyc("ovf_sticky",    1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 4'b0000, 15, 15, 0, 1);
        cyc("ovf_reinit5",   1, 1, 5, 4'h0, 8'h00, 0, 0, 0, 4'b0000, 15,  5, 0, 1);

        cyc("both_apply",    1, 0, 0, 4'h1, 8'h02, 1, 3, 0, 4'b0001,  5,  6, 0, 0);
        cyc("both_idle",     1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 4'b0000,  6,  6, 0, 0);

        cyc("drn_reinit",    1, 1, 12, 4'h0, 8'h00, 0, 0, 0, 4'b0000, 6, 12, 0, 0);
        cyc("drn_on",        1, 0, 0, 4'h0, 8'h00, 0, 0, 1, 4'b0000, 12, 12, 0, 0);
        cyc("drn_ret",       1, 0, 0, 4'hF, 8'h55, 1, 3, 1, 4'b0000, 12, 15, 0, 0);
        cyc("drn_full",      1, 0, 0, 4'hF, 8'h55, 0, 0, 1, 4'b0000, 15, 15, 1, 0);
        cyc("drn_release",   1, 0, 0, 4'hF, 8'h55, 0, 0, 0, 4'b0000, 15, 15, 1, 0);
        cyc("drn_resume",    1, 0, 0, 4'hF, 8'h55, 0, 0, 0, 4'b0001, 15, 14, 0, 0);
        cyc("abort_on",      1, 0, 0, 4'h0, 8'h00, 0, 0, 1, 4'b0000, 14, 14, 0, 0);
        cyc("abort_drain",   1, 0, 0, 4'h1, 8'h01, 0, 0, 0, 4'b0000, 14, 14, 0, 0);
        cyc("abort_run",     1, 0, 0, 4'h1, 8'h01, 0, 0, 0, 4'b0001, 14, 13, 0, 0);
        cyc("abort_idle",    1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 4'b0000, 13, 13, 0, 0);

        cyc("ri_force",      1, 1, 4, 4'hF, 8'h55, 1, 3, 0, 4'b0000, 13,  4, 0, 0);
        cyc("ri_ptr0_zero",  1, 0, 0, 4'hF, 8'h00, 0, 0, 0, 4'b0001,  4,  4, 0, 0);
        cyc("zero_cost",     1, 0, 0, 4'hF, 8'h00, 0, 0, 0, 4'b0010,  4,  4, 0, 0);

        cyc("rst_mid",       0, 0, 0, 4'hF, 8'h00, 0, 0, 0, 4'b0000,  4,  4, 0, 0);
        cyc("rst_rearb",     1, 0, 0, 4'hF, 8'h00, 0, 0, 0, 4'b0001,  8,  8, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_queue: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
